// File: rtl/timer_pkg.sv
// Shared types and defaults for the timeout timer: state encoding, default
// parameters and a helper that converts a small integer to two BCD digits.
package timer_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PAUSE   = 2'b01,
    EXPIRED = 2'b10
  } timer_state_t;

  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int TIMEOUT_DEF  = 30;

  function automatic logic [7:0] to_bcd(input int value);
    return {4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock prescaler: counts enabled cycles 0..TICK_DIV-1 and pulses tick on the
// wrap cycle. The count freezes while run is low and clears on clr.
module tick_gen
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == LAST);
  // Combinational so the pulse lands in the wrap cycle itself; reset gating
  // keeps it low while rst is high even when TICK_DIV is 1.
  assign tick = run && !clr && !rst && wrap;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timeout_timer.sv
// Timeout timer for the vending controller: seconds countdown from TIMEOUT with
// latched t0 flag. Optional BCD display copy when TIMER_BCD_EN is defined.
module timeout_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int SEC_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_timer,
  input  logic             enable,
  output logic             t0,
  output logic             tick,
  output logic [SEC_W-1:0] remaining,
  output logic [1:0]       timer_state
`ifdef TIMER_BCD_EN
  ,
  output logic [7:0]       remaining_bcd
`endif
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("timeout_timer: TICK_DIV must be at least 1");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << SEC_W)) begin : g_bad_timeout
    $error("timeout_timer: TIMEOUT must be in 1 .. 2**SEC_W-1");
  end

  localparam logic [SEC_W-1:0] TIMEOUT_V = SEC_W'(TIMEOUT);

  timer_state_t     state_q, state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic             t0_q, t0_d;
  logic             run, tick_w, dec;

  // The prescaler advances on every enabled cycle, including the one that
  // leaves PAUSE, so each disabled cycle costs exactly one cycle.
  assign run = !rst_timer && enable && (state_q == RUN || state_q == PAUSE);
  assign dec = tick_w && (remaining_q != '0);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (rst_timer),
    .run  (run),
    .tick (tick_w)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    t0_d        = t0_q;
    if (rst_timer) begin
      state_d     = RUN;
      remaining_d = TIMEOUT_V;
      t0_d        = 1'b0;
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (tick_w && remaining_q == SEC_W'(1)) begin
            state_d     = EXPIRED;
            remaining_d = '0;
            t0_d        = 1'b1;
          end else begin
            if (dec) remaining_d = remaining_q - SEC_W'(1);
            state_d = enable ? RUN : PAUSE;
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      remaining_q <= TIMEOUT_V;
      t0_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      t0_q        <= t0_d;
    end
  end

  assign t0          = t0_q;
  assign tick        = tick_w;
  assign remaining   = remaining_q;
  assign timer_state = state_q;

`ifdef TIMER_BCD_EN
  if (TIMEOUT > 99) begin : g_bad_bcd
    $error("timeout_timer: TIMER_BCD_EN needs TIMEOUT <= 99");
  end

  localparam logic [7:0] BCD_INIT = to_bcd(TIMEOUT);

  logic [3:0] tens_q, tens_d, ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (rst_timer) begin
      {tens_d, ones_d} = BCD_INIT;
    end else if (dec) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {tens_q, ones_q} <= BCD_INIT;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign remaining_bcd = {tens_q, ones_q};
`endif

endmodule

// File: tb/tb_timeout_timer.sv
// Self-checking bench for timeout_timer (TICK_DIV=4, TIMEOUT=3): directed
// scenarios plus a randomized run, all checked against an enabled-cycle model.
module tb_timeout_timer;

  localparam int TD = 4;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_timer = 1'b0;
  logic       enable = 1'b0;
  logic       t0, tick;
  logic [7:0] remaining;
  logic [1:0] timer_state;
`ifdef TIMER_BCD_EN
  logic [7:0] remaining_bcd;
`endif

  timeout_timer #(.TICK_DIV(TD), .TIMEOUT(TO), .SEC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rst_timer   (rst_timer),
    .enable      (enable),
    .t0          (t0),
    .tick        (tick),
    .remaining   (remaining),
    .timer_state (timer_state)
`ifdef TIMER_BCD_EN
    ,
    .remaining_bcd (remaining_bcd)
`endif
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: enabled cycles counted since the last reset/restart; everything
  // observable follows from that count and the last enable level.
  int e_cnt = 0;
  bit last_en = 1'b1;
  int cyc = 0;
  int first_t0 = -1;
  int tick_cycles[$];
  logic [31:0] obs_rem;
  logic        obs_t0;

  function automatic bit m_t0();
    return e_cnt >= TO * TD;
  endfunction

  function automatic int m_rem();
    return m_t0() ? 0 : TO - e_cnt / TD;
  endfunction

  function automatic int m_state();
    return m_t0() ? 2 : (last_en ? 0 : 1);
  endfunction

  function automatic bit m_tick(input bit rt, input bit en);
    return !rt && en && !m_t0() && (e_cnt % TD == TD - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock cycle: drive inputs shortly after the edge, check mid-cycle,
  // then advance the model on the rising edge.
  task automatic step(input bit rt, input bit en);
    #1;
    rst_timer = rt;
    enable    = en;
    #3;
    check("tick", tick, m_tick(rt, en));
    check("remaining", remaining, m_rem());
    check("t0", t0, m_t0());
    check("state", timer_state, m_state());
`ifdef TIMER_BCD_EN
    check("bcd", remaining_bcd, 32'(((m_rem() / 10) << 4) | (m_rem() % 10)));
`endif
    obs_rem = remaining;
    obs_t0  = t0;
    if (tick === 1'b1) tick_cycles.push_back(cyc);
    if (t0 === 1'b1 && first_t0 < 0) first_t0 = cyc;
    @(posedge clk);
    if (rt) begin
      e_cnt   = 0;
      last_en = 1'b1;
    end else if (!m_t0()) begin
      if (en) e_cnt++;
      last_en = en;
    end
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_timer = 1'b0;
    rst       = 1'b1;
    #1;
    check("async_rst_t0", t0, 0);
    check("async_rst_rem", remaining, TO);
    check("async_rst_tick", tick, 0);
    check("async_rst_state", timer_state, 0);
    @(posedge clk);
    #2;
    rst      = 1'b0;
    e_cnt    = 0;
    last_en  = 1'b1;
    cyc      = 0;
    first_t0 = -1;
    tick_cycles.delete();
  endtask

  initial begin
    @(posedge clk);

    // Free run from reset: ticks at 3, 7, 11; t0 from cycle 12, held.
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1);
    check("tick_count", tick_cycles.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (tick_cycles.size() > i) check("tick_cycle", tick_cycles[i], 3 + 4 * i);
    end
    check("t0_cycle_free", first_t0, 12);

    // Enable low for cycles 5..9: expiry slips by five cycles.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      step(1'b0, !(k >= 5 && k <= 9));
      if (k >= 5 && k <= 9) check("frozen_rem", obs_rem, 2);
    end
    check("t0_cycle_paused", first_t0, 17);

    // Restart pulse in cycle 6.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(k == 6, 1'b1);
      if (k == 7) begin
        check("restart_rem", obs_rem, TO);
        check("restart_t0", obs_t0, 0);
      end
    end
    check("t0_cycle_restart", first_t0, 19);

    // Restart coinciding with the expiring wrap in cycle 11.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step(k == 11, 1'b1);
      if (k == 12) begin
        check("collide_t0", obs_t0, 0);
        check("collide_rem", obs_rem, TO);
      end
    end
    check("collide_no_expiry", first_t0, -1);

    // Expire, toggle enable, then async reset while expired.
    do_reset();
    for (int k = 0; k < 14; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, k[0]);
      check("expired_hold_t0", obs_t0, 1);
    end
    do_reset();

    // Randomized enable/restart mix.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
